// File: rtl/ball_physics_engine.sv
// Breakout ball stepper: per tick, move the ball and resolve wall, brick, paddle and bottom-loss cases.
// Five-state step; done pulses 4 cycles after the tick is sampled. Ticks seen while busy are dropped.
module ball_physics_engine #(
   parameter int VX     = 8,
   parameter int VY     = 6,
   parameter int BALL_R = 4,
   parameter int PAD_HW = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        run,
   input  logic [9:0]  board_x,
   input  logic [9:0]  board_y,
   output logic [8:0]  rd_idx,
   input  logic [2:0]  rd_data,
   output logic        wr_en,
   output logic [8:0]  wr_idx,
   output logic [2:0]  wr_data,
   output logic [9:0]  ball_x,
   output logic [9:0]  ball_y,
   output logic [1:0]  ball_dir,
   output logic        busy,
   output logic        done,
   output logic        brick_hit,
   output logic        lost,
   output logic [15:0] score
);

   typedef enum logic [2:0] {IDLE, CALC, READ, RESOLVE, COMMIT} state_t;

   localparam logic signed [11:0] VX_S    = 12'(VX);
   localparam logic signed [11:0] VY_S    = 12'(VY);
   localparam logic signed [11:0] R_S     = 12'(BALL_R);
   localparam logic signed [11:0] HW_S    = 12'(PAD_HW);
   localparam logic signed [11:0] XMAX_S  = 12'(639 - BALL_R);
   localparam logic signed [11:0] BRICK_H = 12'sd192;
   localparam logic signed [11:0] Y_BOT   = 12'sd479;

   state_t             state_q, state_d;
   logic [9:0]         ball_x_q, ball_x_d, ball_y_q, ball_y_d;
   logic [1:0]         dir_q, dir_d, wdir_q, wdir_d;
   logic signed [11:0] cx_q, cx_d, cy_q, cy_d;
   logic               top_hit_q, top_hit_d, probe_vld_q, probe_vld_d;
   logic [8:0]         rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
   logic [2:0]         wr_data_q, wr_data_d;
   logic               wr_en_q, wr_en_d, done_q, done_d;
   logic               brick_hit_q, brick_hit_d, lost_q, lost_d;
   logic [15:0]        score_q, score_d;

   logic signed [11:0] x_s, y_s, py_s, bot_s, by_s, adx_s;
   logic [8:0]         row_w, col_w;

   always_comb begin
      state_d     = state_q;
      ball_x_d    = ball_x_q;
      ball_y_d    = ball_y_q;
      dir_d       = dir_q;
      wdir_d      = wdir_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      top_hit_d   = top_hit_q;
      probe_vld_d = probe_vld_q;
      rd_idx_d    = rd_idx_q;
      wr_idx_d    = wr_idx_q;
      wr_data_d   = wr_data_q;
      score_d     = score_q;
      wr_en_d     = 1'b0;
      done_d      = 1'b0;
      brick_hit_d = 1'b0;
      lost_d      = 1'b0;
      x_s         = signed'({2'b00, ball_x_q});
      y_s         = signed'({2'b00, ball_y_q});
      by_s        = signed'({2'b00, board_y});
      py_s        = '0;
      bot_s       = cy_q + R_S;
      adx_s       = cx_q - signed'({2'b00, board_x});
      row_w       = '0;
      col_w       = '0;
      if (adx_s < 0) adx_s = -adx_s;

      case (state_q)
         IDLE: begin
            if (tick && run) state_d = CALC;
         end
         CALC: begin
            wdir_d    = dir_q;
            top_hit_d = 1'b0;
            if (!dir_q[1]) begin
               if (x_s - VX_S < R_S) begin
                  cx_d      = R_S;
                  wdir_d[1] = 1'b1;
               end else begin
                  cx_d = x_s - VX_S;
               end
            end else if (x_s + VX_S > XMAX_S) begin
               cx_d      = XMAX_S;
               wdir_d[1] = 1'b0;
            end else begin
               cx_d = x_s + VX_S;
            end
            if (!dir_q[0] && (y_s - VY_S < R_S)) begin
               cy_d      = R_S;
               wdir_d[0] = 1'b1;
               top_hit_d = 1'b1;
            end else begin
               cy_d = dir_q[0] ? y_s + VY_S : y_s - VY_S;
            end
            state_d = READ;
         end
         READ: begin
            // Probe the leading edge of the ball in its direction of travel.
            py_s  = wdir_q[0] ? cy_q + R_S : cy_q - R_S;
            row_w = {4'b0000, py_s[7:3]};
            col_w = {4'b0000, cx_q[9:5]};
            if ((py_s < BRICK_H) && !top_hit_q) begin
               probe_vld_d = 1'b1;
               rd_idx_d    = row_w * 9'd20 + col_w;
            end else begin
               probe_vld_d = 1'b0;
            end
            state_d = RESOLVE;
         end
         RESOLVE: begin
            if (probe_vld_q && (rd_data != 3'd0)) begin
               wr_en_d     = 1'b1;
               wr_idx_d    = rd_idx_q;
               wr_data_d   = rd_data - 3'd1;
               ball_x_d    = cx_q[9:0];
               dir_d       = {wdir_q[1], ~wdir_q[0]};
               brick_hit_d = 1'b1;
               score_d     = score_q + 16'd1;
            end else if (wdir_q[0] && (bot_s >= by_s) && (bot_s < by_s + VY_S + R_S)
                         && (adx_s <= HW_S)) begin
               ball_x_d = cx_q[9:0];
               ball_y_d = board_y - 10'(BALL_R);
               dir_d    = {wdir_q[1], 1'b0};
            end else if (bot_s > Y_BOT) begin
               lost_d   = 1'b1;
               ball_x_d = 10'd320;
               ball_y_d = 10'd240;
               dir_d    = 2'b10;
            end else begin
               ball_x_d = cx_q[9:0];
               ball_y_d = cy_q[9:0];
               dir_d    = wdir_q;
            end
            done_d  = 1'b1;
            state_d = COMMIT;
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ball_x_q    <= 10'd320;
         ball_y_q    <= 10'd240;
         dir_q       <= 2'b10;
         wdir_q      <= 2'b10;
         cx_q        <= '0;
         cy_q        <= '0;
         top_hit_q   <= 1'b0;
         probe_vld_q <= 1'b0;
         rd_idx_q    <= '0;
         wr_idx_q    <= '0;
         wr_data_q   <= '0;
         wr_en_q     <= 1'b0;
         done_q      <= 1'b0;
         brick_hit_q <= 1'b0;
         lost_q      <= 1'b0;
         score_q     <= '0;
      end else begin
         state_q     <= state_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         dir_q       <= dir_d;
         wdir_q      <= wdir_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         top_hit_q   <= top_hit_d;
         probe_vld_q <= probe_vld_d;
         rd_idx_q    <= rd_idx_d;
         wr_idx_q    <= wr_idx_d;
         wr_data_q   <= wr_data_d;
         wr_en_q     <= wr_en_d;
         done_q      <= done_d;
         brick_hit_q <= brick_hit_d;
         lost_q      <= lost_d;
         score_q     <= score_d;
      end
   end

   assign rd_idx    = rd_idx_q;
   assign wr_en     = wr_en_q;
   assign wr_idx    = wr_idx_q;
   assign wr_data   = wr_data_q;
   assign ball_x    = ball_x_q;
   assign ball_y    = ball_y_q;
   assign ball_dir  = dir_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign brick_hit = brick_hit_q;
   assign lost      = lost_q;
   assign score     = score_q;

endmodule
